// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side signal bundle for the hazard scoreboard.
// The master side (ID/EX/WB control) drives the instruction and writeback
// fields; the slave side (the scoreboard) returns the hold/bubble controls.
interface hazard_scoreboard_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             idValid;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             useRs1;
    logic             useRs2;
    logic [REG_W-1:0] rdId;
    logic             regWriteId;
    logic             longOpId;
    logic             memReadEx;
    logic [REG_W-1:0] rdEx;
    logic             flush;
    logic             wbValid;
    logic [REG_W-1:0] wbRd;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             idExBubble;
    logic             busy;
    logic [CNT_W-1:0] stallCycles;

    modport master (
        output idValid, rs1, rs2, useRs1, useRs2, rdId, regWriteId, longOpId,
        output memReadEx, rdEx, flush, wbValid, wbRd,
        input  pcWrite, ifIdWrite, idExBubble, busy, stallCycles
    );

    modport slave (
        input  idValid, rs1, rs2, useRs1, useRs2, rdId, regWriteId, longOpId,
        input  memReadEx, rdEx, flush, wbValid, wbRd,
        output pcWrite, ifIdWrite, idExBubble, busy, stallCycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline.
// Keeps a pending bitmap of destinations owned by in-flight long-latency ops
// and stalls ID (hold PC and IF/ID, bubble into ID/EX) until every operand
// the instruction needs can be supplied by the EX/WB bypass network.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_scoreboard_if.slave   bus
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] eff_pend;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;
    logic                hz1;
    logic                hz2;
    logic                waw;
    logic                stall;
    logic                issue;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // One-hot of the register being written back this cycle; this write is
    // visible through the WB bypass, so it no longer blocks a reader.
    always_comb begin
        wb_mask = '0;
        if (bus.wbValid) begin
            wb_mask[bus.wbRd] = 1'b1;
        end
        eff_pend = pending_q & ~wb_mask;
    end

    // Hazard detection at ID. x0 never creates a hazard. A flushed or invalid
    // ID slot never stalls, and reset forces the pipeline to run freely.
    always_comb begin
        hz1   = bus.useRs1 && (bus.rs1 != '0) &&
                (eff_pend[bus.rs1] || (bus.memReadEx && (bus.rdEx == bus.rs1)));
        hz2   = bus.useRs2 && (bus.rs2 != '0) &&
                (eff_pend[bus.rs2] || (bus.memReadEx && (bus.rdEx == bus.rs2)));
        waw   = bus.regWriteId && (bus.rdId != '0) && eff_pend[bus.rdId];
        stall = !rst && bus.idValid && !bus.flush && (hz1 || hz2 || waw);
        issue = bus.idValid && !bus.flush && !stall && bus.regWriteId &&
                bus.longOpId && (bus.rdId != '0);
    end

    // Next pending bitmap: clear on writeback first, then set on issue so a
    // same-register collision keeps the younger writer's claim.
    always_comb begin
        pending_d = pending_q;
        if (bus.wbValid && (bus.wbRd != '0)) begin
            pending_d[bus.wbRd] = 1'b0;
        end
        if (issue) begin
            pending_d[bus.rdId] = 1'b1;
        end
        pending_d[0] = 1'b0;
        stall_cnt_d  = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // Scoreboard state and stall statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Pipeline controls follow the stall decision in the same cycle.
    always_comb begin
        bus.pcWrite     = !stall;
        bus.ifIdWrite   = !stall;
        bus.idExBubble  = stall;
        bus.busy        = !rst && (|pending_q);
        bus.stallCycles = stall_cnt_q;
    end

endmodule
